// File: rtl/ram_scan_reader_if.sv
// Bundle of scan-control, RAM read-port and display signals for ram_scan_reader.
// slave is the reader; master is whatever drives the controls and owns the RAMs.
interface ram_scan_reader_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic            start;
  logic            abort;
  logic            mode;
  logic            step;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data0;
  logic [DW-1:0]   rd_data1;
  logic [AW-1:0]   disp_addr;
  logic [DW-1:0]   disp_data0;
  logic [DW-1:0]   disp_data1;
  logic            mismatch;
  logic [AW:0]     mism_cnt;
  logic [DW+AW-1:0] sum0;
  logic            busy;
  logic            done;

  modport slave (
    input  start, abort, mode, step, rd_data0, rd_data1,
    output rd_addr, disp_addr, disp_data0, disp_data1, mismatch, mism_cnt, sum0, busy, done
  );

  modport master (
    output start, abort, mode, step, rd_data0, rd_data1,
    input  rd_addr, disp_addr, disp_data0, disp_data1, mismatch, mism_cnt, sum0, busy, done
  );
endinterface

// File: rtl/ram_scan_reader.sv
// Walks both RAMs in lockstep, latching each word pair for display while
// accumulating a RAM0 checksum and a count of RAM0/RAM1 differences.
module ram_scan_reader #(
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DWELL = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  ram_scan_reader_if.slave bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = DW + AW;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_HOLD, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_disp_addr;
  logic [DW-1:0]   r_disp0;
  logic [DW-1:0]   r_disp1;
  logic            r_mismatch;
  logic [AW:0]     r_mism_cnt;
  logic [SW-1:0]   r_sum0;
  logic [CW-1:0]   r_dwell;

  logic w_begin, w_capt, w_advance, w_count;
  logic w_last, w_diff, w_go;

  assign w_last = (r_addr == {AW{1'b1}});
  assign w_diff = (bus.rd_data0 != bus.rd_data1);
  // Manual mode advances on step; auto mode on the last dwell cycle.
  assign w_go   = bus.mode ? bus.step : (r_dwell == CW'(DWELL - 1));

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_begin      = 1'b0;
    w_capt       = 1'b0;
    w_advance    = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_begin      = 1'b1;
          w_state_next = S_READ;
        end
      end
      S_READ: w_state_next = bus.abort ? S_IDLE : S_CAPT;
      S_CAPT: begin
        if (bus.abort) w_state_next = S_IDLE;
        else begin
          w_capt       = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.abort) w_state_next = S_IDLE;
        else if (w_go) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? S_DONE : S_READ;
        end else begin
          w_count = ~bus.mode;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_disp_addr <= '0;
      r_disp0     <= '0;
      r_disp1     <= '0;
      r_mismatch  <= 1'b0;
      r_mism_cnt  <= '0;
      r_sum0      <= '0;
      r_dwell     <= '0;
    end else begin
      // Display registers are deliberately left alone until the first capture.
      if (w_begin) begin
        r_addr     <= '0;
        r_sum0     <= '0;
        r_mism_cnt <= '0;
        r_mismatch <= 1'b0;
      end
      if (w_capt) begin
        r_disp_addr <= r_addr;
        r_disp0     <= bus.rd_data0;
        r_disp1     <= bus.rd_data1;
        r_mismatch  <= w_diff;
        r_sum0      <= r_sum0 + SW'(bus.rd_data0);
        r_mism_cnt  <= r_mism_cnt + (AW+1)'(w_diff);
        r_dwell     <= '0;
      end
      if (w_count) r_dwell <= r_dwell + CW'(1);
      if (w_advance && !w_last) r_addr <= r_addr + AW'(1);
    end
  end

  assign bus.rd_addr    = r_addr;
  assign bus.disp_addr  = r_disp_addr;
  assign bus.disp_data0 = r_disp0;
  assign bus.disp_data1 = r_disp1;
  assign bus.mismatch   = r_mismatch;
  assign bus.mism_cnt   = r_mism_cnt;
  assign bus.sum0       = r_sum0;
  assign bus.busy       = (r_state == S_READ) || (r_state == S_CAPT) || (r_state == S_HOLD);
  assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: table of RAM images, hand-written corner sequences
// and randomized control traffic, all checked against a word-level model.
module tb_ram_scan_reader;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DWELL = 3;
  localparam int NW    = 16;
  localparam int PER   = DWELL + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_scan_reader_if #(.AW(AW), .DW(DW)) bus ();

  ram_scan_reader #(.AW(AW), .DW(DW), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  logic [DW-1:0] mem0 [NW];
  logic [DW-1:0] mem1 [NW];

  // Two RAMs with one-cycle registered read.
  always @(posedge clk) begin
    bus.rd_data0 <= mem0[bus.rd_addr];
    bus.rd_data1 <= mem1[bus.rd_addr];
  end

  int n_pass  = 0;
  int n_total = 0;
  int e       = 0;

  typedef struct {
    logic [63:0] m0;
    logic [63:0] m1;
    int          exp_sum;
    int          exp_mism;
    logic        exp_last_mism;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e = 0;
  endtask

  function automatic int psum(input int n);
    int s = 0;
    for (int a = 0; a <= n; a++) s += int'(mem0[a]);
    return s;
  endfunction

  function automatic int pmism(input int n);
    int c = 0;
    for (int a = 0; a <= n; a++) if (mem0[a] != mem1[a]) c++;
    return c;
  endfunction

  task automatic load(input logic [63:0] m0, input logic [63:0] m1);
    for (int a = 0; a < NW; a++) begin
      mem0[a] = m0[a*4 +: 4];
      mem1[a] = m1[a*4 +: 4];
    end
  endtask

  task automatic load_rand();
    for (int a = 0; a < NW; a++) begin
      mem0[a] = 4'($urandom);
      mem1[a] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : mem0[a];
    end
  endtask

  task automatic check_word(input string tag, input int i);
    check($sformatf("%s w%0d disp_addr", tag, i), 32'(bus.disp_addr), 32'(i));
    check($sformatf("%s w%0d data0", tag, i), 32'(bus.disp_data0), 32'(mem0[i]));
    check($sformatf("%s w%0d data1", tag, i), 32'(bus.disp_data1), 32'(mem1[i]));
    check($sformatf("%s w%0d mismatch", tag, i), 32'(bus.mismatch), 32'(mem0[i] != mem1[i]));
    check($sformatf("%s w%0d sum0", tag, i), 32'(bus.sum0), 32'(psum(i)));
    check($sformatf("%s w%0d mism_cnt", tag, i), 32'(bus.mism_cnt), 32'(pmism(i)));
    check($sformatf("%s w%0d busy", tag, i), 32'(bus.busy), 32'd1);
  endtask

  task automatic check_final(input string tag);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " disp_addr"}, 32'(bus.disp_addr), 32'(NW - 1));
    check({tag, " data0"}, 32'(bus.disp_data0), 32'(mem0[NW-1]));
    check({tag, " data1"}, 32'(bus.disp_data1), 32'(mem1[NW-1]));
    check({tag, " sum0"}, 32'(bus.sum0), 32'(psum(NW - 1)));
    check({tag, " mism_cnt"}, 32'(bus.mism_cnt), 32'(pmism(NW - 1)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_addr"}, 32'(bus.rd_addr), 32'd0);
    check({tag, " disp_addr"}, 32'(bus.disp_addr), 32'd0);
    check({tag, " data0"}, 32'(bus.disp_data0), 32'd0);
    check({tag, " data1"}, 32'(bus.disp_data1), 32'd0);
    check({tag, " mismatch"}, 32'(bus.mismatch), 32'd0);
    check({tag, " mism_cnt"}, 32'(bus.mism_cnt), 32'd0);
    check({tag, " sum0"}, 32'(bus.sum0), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (!bus.done && k < bound) begin
      tick();
      k++;
    end
    check({tag, " done reached"}, 32'(bus.done), 32'd1);
  endtask

  // Full auto scan, checking every captured word and the exact done edge.
  task automatic auto_scan(input string tag);
    bus.mode = 1'b0;
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      run_to(i * PER + 2);
      check_word(tag, i);
    end
    run_to(NW * PER - 1);
    check({tag, " done early"}, 32'(bus.done), 32'd0);
    tick();
    check_final(tag);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = 1'b0;
    bus.step  = 1'b0;
    load(64'h0, 64'h0);

    vecs[0] = '{64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 120, 0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_F000_0000, 240, 15, 1'b1};
    vecs[2] = '{64'h0, 64'h0, 0, 0, 1'b0};
    vecs[3] = '{64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 120, 16, 1'b1};

    // Reset state and idle behaviour.
    #23;
    check_zero("reset");
    rst_n = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (4) tick();
    check("idle busy", 32'(bus.busy), 32'd0);
    check("idle done", 32'(bus.done), 32'd0);

    // Table-driven full scans.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].m0, vecs[v].m1);
      auto_scan($sformatf("vec%0d", v));
      check($sformatf("vec%0d tbl sum0", v), 32'(bus.sum0), 32'(vecs[v].exp_sum));
      check($sformatf("vec%0d tbl mism_cnt", v), 32'(bus.mism_cnt), 32'(vecs[v].exp_mism));
      check($sformatf("vec%0d tbl mismatch", v), 32'(bus.mismatch), 32'(vecs[v].exp_last_mism));
    end

    // Manual stepping, with a step held into READ that must be ignored.
    load_rand();
    bus.mode = 1'b1;
    pulse_start();
    run_to(2);
    check_word("man", 0);
    run_to(52);
    check_word("man hold", 0);
    bus.step = 1'b1;
    tick();
    tick();
    bus.step = 1'b0;
    repeat (5) tick();
    check("man step1 disp_addr", 32'(bus.disp_addr), 32'd1);
    for (int s = 0; s < 2; s++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      repeat (5) tick();
    end
    e = 0;
    check_word("man step3", 3);
    bus.mode = 1'b0;
    wait_done("man", 200);
    check_final("man");

    // Abort at address 5, then restart.
    load_rand();
    bus.mode = 1'b0;
    pulse_start();
    run_to(5 * PER + 3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort disp_addr", 32'(bus.disp_addr), 32'd5);
    check("abort data0", 32'(bus.disp_data0), 32'(mem0[5]));
    check("abort sum0", 32'(bus.sum0), 32'(psum(5)));
    check("abort mism_cnt", 32'(bus.mism_cnt), 32'(pmism(5)));
    repeat (10) tick();
    check("abort idle busy", 32'(bus.busy), 32'd0);
    pulse_start();
    check("restart sum0", 32'(bus.sum0), 32'd0);
    check("restart mism_cnt", 32'(bus.mism_cnt), 32'd0);
    check("restart mismatch", 32'(bus.mismatch), 32'd0);
    check("restart rd_addr", 32'(bus.rd_addr), 32'd0);
    check("restart busy", 32'(bus.busy), 32'd1);
    check("restart disp kept", 32'(bus.disp_addr), 32'd5);
    run_to(2);
    check_word("restart", 0);
    run_to(NW * PER);
    check_final("restart");

    // Asynchronous reset in HOLD of address 9.
    load_rand();
    pulse_start();
    run_to(9 * PER + 3);
    check("pre-rst disp_addr", 32'(bus.disp_addr), 32'd9);
    #2 rst_n = 1'b0;
    #1 check_zero("async rst");
    #2 rst_n = 1'b1;
    repeat (5) tick();
    check("post-rst busy", 32'(bus.busy), 32'd0);
    check("post-rst done", 32'(bus.done), 32'd0);
    check("post-rst rd_addr", 32'(bus.rd_addr), 32'd0);

    // start while busy is ignored; start+abort while busy aborts.
    load_rand();
    pulse_start();
    run_to(12);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_to(3 * PER + 2);
    check_word("busy start", 3);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("st+ab busy", 32'(bus.busy), 32'd0);
    check("st+ab done", 32'(bus.done), 32'd0);
    check("st+ab disp_addr", 32'(bus.disp_addr), 32'd3);

    // start+abort while idle: start wins.
    bus.abort = 1'b1;
    pulse_start();
    bus.abort = 1'b0;
    check("idle st+ab busy", 32'(bus.busy), 32'd1);
    check("idle st+ab sum0", 32'(bus.sum0), 32'd0);
    run_to(NW * PER);
    check_final("idle st+ab");

    // abort in DONE has no effect; start in DONE rescans.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_final("done abort");
    pulse_start();
    check("rescan done", 32'(bus.done), 32'd0);
    check("rescan busy", 32'(bus.busy), 32'd1);
    check("rescan sum0", 32'(bus.sum0), 32'd0);
    check("rescan mism_cnt", 32'(bus.mism_cnt), 32'd0);
    run_to(NW * PER);
    check_final("rescan");

    // Randomized mode/step/start traffic; final results depend only on RAM contents.
    for (int it = 0; it < 6; it++) begin
      load_rand();
      bus.mode = 1'($urandom);
      pulse_start();
      for (int k = 0; k < 3000 && !bus.done; k++) begin
        if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
        bus.step  = ($urandom_range(0, 3) == 0);
        bus.start = ($urandom_range(0, 15) == 0);
        tick();
      end
      bus.start = 1'b0;
      bus.step  = 1'b0;
      bus.mode  = 1'b0;
      check_final($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
Name: ram_scan_reader

Overview:
- Read-side companion to the dual 16x4 RAM write path.
- Walks every address of RAM0 and RAM1 in lockstep and latches each word pair for the HEX displays.
- Accumulates a RAM0 checksum and counts RAM0/RAM1 mismatches.
- Sits between the two ram instances' read ports and the hex_display drivers. It is driven by a start pulse, and either advances automatically after a dwell time or advances on manual step pulses.

Parameters:
- AW, 4: address width; scan covers 0 .. 2^AW-1.
- DW, 4: data word width of each RAM.
- DWELL, 25000000: cycles each word is held in auto mode. Must be >= 1. Benches use 3.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a scan when idle or done.
- abort  input  1  single-cycle pulse; ends a scan early.
- mode  input  1  0 = auto advance after DWELL cycles; 1 = manual step.
- step  input  1  single-cycle, already-debounced pulse; advances in manual mode.
- rd_addr  output  AW  address driven to both RAMs.
- rd_data0  input  DW  RAM0 read data; valid 1 cycle after rd_addr.
- rd_data1  input  DW  RAM1 read data; valid 1 cycle after rd_addr.
- disp_addr  output  AW  address of the displayed word pair.
- disp_data0  output  DW  latched RAM0 word.
- disp_data1  output  DW  latched RAM1 word.
- mismatch  output  1  displayed pair differs.
- mism_cnt  output  AW+1  number of differing pairs in the scan so far.
- sum0  output  DW+AW  sum of RAM0 words captured so far.
- busy  output  1  scan in progress.
- done  output  1  scan completed.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0.
- States: IDLE, READ, CAPT, HOLD, DONE.
- IDLE/DONE, start=1:
  - rd_addr<=0; sum0, mism_cnt, mismatch <= 0; done<=0; busy<=1; next state READ.
  - disp_* keep their previous values until the first CAPT.
- READ: rd_addr stable for one cycle (RAM read latency); next state CAPT.
- CAPT:
  - disp_addr<=rd_addr; disp_data0<=rd_data0; disp_data1<=rd_data1.
  - mismatch<=(rd_data0!=rd_data1).
  - sum0<=sum0+zero-extended rd_data0.
  - mism_cnt<=mism_cnt+mismatch value; dwell counter<=0; next state HOLD.
- HOLD, mode=0:
  - Dwell counter increments each cycle.
  - On the cycle where counter==DWELL-1, advance.
- HOLD, mode=1: advance on a cycle with step=1. Step on any other cycle, or in any other state, is ignored.
- mode is sampled only in HOLD. A change mid-hold takes effect on the next HOLD cycle; the dwell counter is not cleared.
- Advance:
  - If rd_addr==2^AW-1: busy<=0, done<=1, state DONE.
  - Otherwise rd_addr<=rd_addr+1 and state READ.
  - rd_addr never wraps during a scan.
- Auto-mode timing: with start sampled at edge 0, word i enters READ at edge i*(DWELL+2). done rises at edge 2^AW*(DWELL+2).
- DONE: all outputs held; done stays 1 until the next start.
- start while busy: ignored.
- abort while busy: state IDLE, busy<=0, done stays 0; disp_*, sum0, mism_cnt retained.
- abort in IDLE or DONE: no effect.
- start and abort in the same cycle:
  - Idle: start wins.
  - Busy: abort wins.
- Width rules:
  - sum0 has DW+AW bits; maximum 16*15=240, so no overflow.
  - mism_cnt has AW+1 bits; maximum 16.
- Reset mid-scan: immediate return to the reset state regardless of phase.

Test Plan:
- RAM0=RAM1=address value (0..F), DWELL=3, mode=0, start pulse -> disp_addr steps 0..F every 5 cycles; done rises at 80 cycles after start; sum0=120 (0x78); mism_cnt=0.
- RAM0 all F, RAM1 all 0 except addr 7=F -> mismatch=1 for every word except 7; final mism_cnt=15, sum0=240.
- mode=1, no step for 50 cycles -> stays at disp_addr=0; 3 step pulses -> disp_addr=3; switch to mode=0 -> completes with done=1.
- Abort pulse at disp_addr=5 -> busy=0, done=0, disp_addr=5 retained; later start -> sum0/mism_cnt cleared and scan restarts at 0.
- rst=0 asserted in HOLD of address 9 -> all outputs 0 asynchronously (before the next clk edge); after release, state idle until start.
- start pulsed during a busy scan and simultaneously with abort -> first ignored; second aborts. start in DONE -> done falls next cycle and rescan begins.
